// File: rtl/sd_spi_byte_xfer_pkg.sv
// sd_spi_pkg: shared types and constants for the SD-card SPI byte transceiver.
//   state_e    - transceiver FSM states
//   MODE_*     - i_mode encodings (slow init rate / fast data rate)
//   *_IDLE     - pin levels while no byte is moving
package sd_spi_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;
    localparam logic MODE_SLOW = 1'b0;
    localparam logic MODE_FAST = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MOSI_IDLE = 1'b1;
endpackage

// File: rtl/sd_spi_byte_xfer_if.sv
// sd_spi_byte_xfer_if: host-side handshake between the SD command/init controller and the byte transceiver.
//   i_mode, i_start, i_tx_byte, i_cs_assert - controller -> transceiver
//   o_busy, o_done, o_rx_byte               - transceiver -> controller
interface sd_spi_byte_xfer_if;
    logic       i_mode;
    logic       i_start;
    logic [7:0] i_tx_byte;
    logic       i_cs_assert;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_rx_byte;
    modport master (output i_mode, i_start, i_tx_byte, i_cs_assert, input o_busy, o_done, o_rx_byte);
    modport slave  (input i_mode, i_start, i_tx_byte, i_cs_assert, output o_busy, o_done, o_rx_byte);
endinterface

// File: rtl/sd_spi_byte_xfer_half_tick.sv
// sd_spi_half_tick: loadable half-period counter; ticks when the count reaches HALF-1.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_clr          - force the count back to 0
//   i_load, i_half - capture a new HALF value
//   o_tick         - count == HALF-1 (the count wraps to 0 on the next edge)
module sd_spi_half_tick #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_half,
    output logic         o_tick
);
    logic [W-1:0] cnt_q, cnt_d, half_q, half_d;

    assign o_tick = cnt_q == half_q - W'(1);

    always_comb begin
        half_d = i_load ? i_half : half_q;
        cnt_d  = (i_clr || o_tick) ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            half_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end
endmodule

// File: rtl/sd_spi_byte_xfer.sv
// sd_spi_byte_xfer: SPI mode-0 master byte transceiver (MSB first) for the SD-card path.
//   i_clk, i_rst_n          - clock, async active-low reset
//   host (slave modport)    - start/mode/tx byte/cs request in; busy/done/rx byte out
//   o_sclk, o_mosi, i_miso  - SPI pins (sclk idles low, mosi idles high)
//   o_cs_n                  - chip select, registered ~i_cs_assert
module sd_spi_byte_xfer
    import sd_spi_pkg::*;
#(
    parameter int SLOW_HALF = 125,
    parameter int FAST_HALF = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    sd_spi_byte_xfer_if.slave        host,
    output logic                     o_sclk,
    output logic                     o_mosi,
    input  logic                     i_miso,
    output logic                     o_cs_n
);
    localparam int HALF_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int CW       = $clog2(HALF_MAX) + 1;

    state_e       state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   tx_q, tx_d, rx_sr_q, rx_sr_d, rx_byte_q, rx_byte_d;
    logic         sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic         tick, clr, load;
    logic [CW-1:0] half_sel;

    assign half_sel = (host.i_mode == MODE_FAST) ? CW'(FAST_HALF) : CW'(SLOW_HALF);

    sd_spi_half_tick #(.W(CW)) u_half_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (clr),
        .i_load  (load),
        .i_half  (half_sel),
        .o_tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_sr_d   = rx_sr_q;
        rx_byte_d = rx_byte_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = ~host.i_cs_assert;
        clr       = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (host.i_start) begin
                    load      = 1'b1;
                    tx_d      = host.i_tx_byte;
                    mosi_d    = host.i_tx_byte[7];
                    bit_cnt_d = '0;
                    state_d   = LOW;
                end
            end
            LOW: if (tick) begin
                sclk_d  = 1'b1;
                rx_sr_d = {rx_sr_q[6:0], i_miso};
                state_d = HIGH;
            end
            HIGH: if (tick) begin
                sclk_d = 1'b0;
                if (bit_cnt_q == 3'd7) begin
                    mosi_d    = MOSI_IDLE;
                    rx_byte_d = rx_sr_q;   // published on entry so it is valid in the done cycle
                    state_d   = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    tx_d      = {tx_q[6:0], 1'b0};
                    mosi_d    = tx_q[6];
                    state_d   = LOW;
                end
            end
            default: begin
                clr     = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_sr_q   <= '0;
            rx_byte_q <= '0;
            sclk_q    <= SCLK_IDLE;
            mosi_q    <= MOSI_IDLE;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_sr_q   <= rx_sr_d;
            rx_byte_q <= rx_byte_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign host.o_busy    = state_q != IDLE;
    assign host.o_done    = state_q == DONE;
    assign host.o_rx_byte = rx_byte_q;
    assign o_sclk         = sclk_q;
    assign o_mosi         = mosi_q;
    assign o_cs_n         = cs_n_q;
endmodule

// File: tb/tb_sd_spi_byte_xfer.sv
// tb_sd_spi_byte_xfer: directed self-checking bench for sd_spi_byte_xfer.
module tb_sd_spi_byte_xfer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk, mosi, miso, cs_n;
    logic [1:0] miso_sel = 2'd0;
    int         checks = 0;
    int         errors = 0;

    int         done_cyc, done_cnt, busy_first, busy_last, rises;
    int         rise_at [8];
    logic [7:0] mosi_bits, rx_at_done;
    logic       mosi_at_done;

    sd_spi_byte_xfer_if bus();

    // 0: loop MOSI back, 1: tie high, otherwise tie low
    assign miso = (miso_sel == 2'd0) ? mosi : (miso_sel == 2'd1);

    sd_spi_byte_xfer #(.SLOW_HALF(125), .FAST_HALF(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .host    (bus),
        .o_sclk  (sclk),
        .o_mosi  (mosi),
        .i_miso  (miso),
        .o_cs_n  (cs_n)
    );

    always #5 clk = ~clk;

    // Starts one byte and records what it sees at each negedge; n counts cycles after the start edge.
    task automatic run_byte(input logic mode, input logic [7:0] tx, input int chg_at, input logic chg_mode,
                            input logic [7:0] chg_tx, input int pulse_at);
        logic prev;
        done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; rises = 0;
        mosi_bits = 8'h00; rx_at_done = 8'h00; mosi_at_done = 1'b0;
        for (int i = 0; i < 8; i++) rise_at[i] = -1;
        @(negedge clk);
        bus.i_mode = mode; bus.i_tx_byte = tx; bus.i_start = 1'b1;
        prev = sclk;
        for (int n = 1; n <= 16 * 125 + 40; n++) begin
            @(negedge clk);
            if (n == 1) bus.i_start = 1'b0;
            if (bus.o_busy) begin
                if (busy_first < 0) busy_first = n;
                busy_last = n;
            end
            if (bus.o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = n; rx_at_done = bus.o_rx_byte; mosi_at_done = mosi;
                end
            end
            if (sclk && !prev) begin
                if (rises < 8) begin
                    rise_at[rises] = n; mosi_bits[7-rises] = mosi;
                end
                rises++;
            end
            prev = sclk;
            if (n == chg_at) begin bus.i_mode = chg_mode; bus.i_tx_byte = chg_tx; end
            if (n == pulse_at) bus.i_start = 1'b1;
            if (n == pulse_at + 1) bus.i_start = 1'b0;
            if (done_cyc > 0 && n >= done_cyc + 10) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi got %b want 1", mosi); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.o_done); end
        checks++; if (bus.o_rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", bus.o_rx_byte); end
        rst_n = 1'b1;
    endtask

    task automatic test_cs();
        @(negedge clk);
        bus.i_cs_assert = 1'b1;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL cs_latency got %b want 1", cs_n); end
        @(negedge clk);
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL cs_assert got %b want 0", cs_n); end
        bus.i_cs_assert = 1'b0;
        @(negedge clk);
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL cs_deassert got %b want 1", cs_n); end
        bus.i_cs_assert = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_slow_loopback();
        miso_sel = 2'd0;
        run_byte(1'b0, 8'hA5, 0, 1'b0, 8'h00, 0);
        checks++; if (rx_at_done !== 8'hA5) begin errors++; $display("FAIL slow_rx got %h want a5", rx_at_done); end
        checks++; if (done_cyc !== 2001) begin errors++; $display("FAIL slow_done_cycle got %0d want 2001", done_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL slow_done_count got %0d want 1", done_cnt); end
        checks++; if (busy_first !== 1) begin errors++; $display("FAIL slow_busy_first got %0d want 1", busy_first); end
        checks++; if (busy_last !== 2001) begin errors++; $display("FAIL slow_busy_last got %0d want 2001", busy_last); end
        checks++; if (rises !== 8) begin errors++; $display("FAIL slow_rises got %0d want 8", rises); end
        checks++; if (rise_at[0] !== 126) begin errors++; $display("FAIL slow_first_rise got %0d want 126", rise_at[0]); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (rise_at[i] - rise_at[i-1] !== 250) begin errors++; $display("FAIL slow_rise_gap%0d got %0d want 250", i, rise_at[i] - rise_at[i-1]); end
        end
        checks++; if (mosi_bits !== 8'hA5) begin errors++; $display("FAIL slow_mosi_bits got %h want a5", mosi_bits); end
    endtask

    task automatic test_fast_ones();
        miso_sel = 2'd1;
        run_byte(1'b1, 8'h3C, 0, 1'b0, 8'h00, 10);
        checks++; if (rx_at_done !== 8'hFF) begin errors++; $display("FAIL fast_rx got %h want ff", rx_at_done); end
        checks++; if (done_cyc !== 33) begin errors++; $display("FAIL fast_done_cycle got %0d want 33", done_cyc); end
        checks++; if (mosi_bits !== 8'h3C) begin errors++; $display("FAIL fast_mosi_bits got %h want 3c", mosi_bits); end
        checks++; if (rise_at[0] !== 3) begin errors++; $display("FAIL fast_first_rise got %0d want 3", rise_at[0]); end
        checks++; if (rises !== 8) begin errors++; $display("FAIL fast_rises got %0d want 8", rises); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", done_cnt); end
        checks++; if (busy_last !== 33) begin errors++; $display("FAIL busy_start_busy_last got %0d want 33", busy_last); end
    endtask

    task automatic test_msb_only();
        miso_sel = 2'd2;
        @(negedge clk);
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL idle_sclk got %b want 0", sclk); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL idle_mosi got %b want 1", mosi); end
        run_byte(1'b1, 8'h80, 0, 1'b0, 8'h00, 0);
        checks++; if (mosi_bits !== 8'h80) begin errors++; $display("FAIL msb_mosi_bits got %h want 80", mosi_bits); end
        checks++; if (mosi_at_done !== 1'b1) begin errors++; $display("FAIL msb_mosi_after got %b want 1", mosi_at_done); end
        checks++; if (rx_at_done !== 8'h00) begin errors++; $display("FAIL msb_rx got %h want 00", rx_at_done); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL msb_sclk_after got %b want 0", sclk); end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1, dn = 0;
        logic [7:0] r1 = 8'h00, r2 = 8'h00;
        logic b34 = 1'b1, b35 = 1'b0;
        miso_sel = 2'd0;
        @(negedge clk);
        bus.i_mode = 1'b1; bus.i_tx_byte = 8'h11; bus.i_start = 1'b1;
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk);
            if (n == 1) bus.i_tx_byte = 8'h22;
            if (n == 50) bus.i_start = 1'b0;
            if (n == 34) b34 = bus.o_busy;
            if (n == 35) b35 = bus.o_busy;
            if (bus.o_done) begin
                dn++;
                if (d1 < 0) begin d1 = n; r1 = bus.o_rx_byte; end
                else if (d2 < 0) begin d2 = n; r2 = bus.o_rx_byte; end
            end
        end
        checks++; if (d1 !== 33) begin errors++; $display("FAIL b2b_done1 got %0d want 33", d1); end
        checks++; if (r1 !== 8'h11) begin errors++; $display("FAIL b2b_rx1 got %h want 11", r1); end
        checks++; if (b34 !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy got %b want 0", b34); end
        checks++; if (b35 !== 1'b1) begin errors++; $display("FAIL b2b_second_busy got %b want 1", b35); end
        checks++; if (d2 !== 67) begin errors++; $display("FAIL b2b_done2 got %0d want 67", d2); end
        checks++; if (r2 !== 8'h22) begin errors++; $display("FAIL b2b_rx2 got %h want 22", r2); end
        checks++; if (dn !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", dn); end
    endtask

    task automatic test_midchange();
        miso_sel = 2'd0;
        run_byte(1'b1, 8'h5A, 5, 1'b0, 8'hFF, 0);
        checks++; if (done_cyc !== 33) begin errors++; $display("FAIL mid_done_cycle got %0d want 33", done_cyc); end
        checks++; if (rx_at_done !== 8'h5A) begin errors++; $display("FAIL mid_rx got %h want 5a", rx_at_done); end
        checks++; if (mosi_bits !== 8'h5A) begin errors++; $display("FAIL mid_mosi_bits got %h want 5a", mosi_bits); end
        run_byte(bus.i_mode, 8'h0F, 0, 1'b0, 8'h00, 0);
        checks++; if (done_cyc !== 2001) begin errors++; $display("FAIL rate_next_done got %0d want 2001", done_cyc); end
        checks++; if (rx_at_done !== 8'h0F) begin errors++; $display("FAIL rate_next_rx got %h want 0f", rx_at_done); end
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        miso_sel = 2'd0;
        @(negedge clk);
        bus.i_mode = 1'b0; bus.i_tx_byte = 8'hC3; bus.i_start = 1'b1;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            if (n == 1) bus.i_start = 1'b0;
            if (bus.o_done) dn++;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk got %b want 0", sclk); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL rst_mid_mosi got %b want 1", mosi); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n got %b want 1", cs_n); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_rx_byte !== 8'h00) begin errors++; $display("FAIL rst_mid_rx got %h want 00", bus.o_rx_byte); end
        repeat (3) begin @(negedge clk); if (bus.o_done) dn++; end
        rst_n = 1'b1;
        repeat (5) begin @(negedge clk); if (bus.o_done || bus.o_busy) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", dn); end
        run_byte(1'b1, 8'h96, 0, 1'b0, 8'h00, 0);
        checks++; if (done_cyc !== 33) begin errors++; $display("FAIL rst_after_done got %0d want 33", done_cyc); end
        checks++; if (rx_at_done !== 8'h96) begin errors++; $display("FAIL rst_after_rx got %h want 96", rx_at_done); end
    endtask

    initial begin
        bus.i_mode = 1'b0; bus.i_start = 1'b0; bus.i_tx_byte = 8'h00; bus.i_cs_assert = 1'b0;
        test_reset();
        test_cs();
        test_slow_loopback();
        test_fast_ones();
        test_msb_only();
        test_back_to_back();
        test_midchange();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
